fb_display_arbiter: RTL and testbench

Shares one single-port frame-buffer BRAM between two requesters. The first is the VGA display fetch, driven by the 640x480 timing generator's pix_stb/active/x/y/animate/screenend. The second is the image-filter client, which uses a req/gnt handshake. The display always wins its slot. The frame buffer holds a downscaled IMG_W x IMG_H image that the arbiter upscales by 2^SHIFT through address generation. An optional tear-free mode restricts client writes to vertical blanking.

---
 rtl/fb_pkg.sv | 34 +++
 rtl/fb_display_arbiter_if.sv | 34 +++
 rtl/fb_addr_gen.sv | 51 +++++
 rtl/fb_display_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_fb_display_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the frame-buffer display arbiter.
//   HA_STA    first raw x count of the visible region
//   H_ACTIVE  visible pixels per line
//   V_ACTIVE  visible lines per frame
//   slot_e    what the single BRAM port is used for in a given cycle
//   state_e   frame phase (visible lines or vertical blanking)
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int HA_STA   = 160;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        DISP   = 2'd1,
        BLANK  = 2'd2,
        CLIENT = 2'd3
    } slot_e;

    typedef enum logic {
        ACTIVE_FRAME = 1'b0,
        VBLANK       = 1'b1
    } state_e;

    // Visible column from the raw horizontal count. Counts left of the
    // visible region wrap to large values and so fall outside 0..H_ACTIVE-1.
    function automatic logic [9:0] col_of(input logic [9:0] x);
        return x - 10'(HA_STA);
    endfunction

endpackage

// File: rtl/fb_display_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_display_arbiter_if
// Image-filter client port of the frame-buffer arbiter.
//   cl_req/cl_we/cl_addr/cl_wdata  request, held by the client until cl_gnt
//   cl_gnt                         request accepted this cycle
//   cl_rvalid/cl_rdata             read data return (pulse / held data)
//   cl_err                         accepted request was outside the image
// Modports: master = client side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fb_display_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) ();

    logic              cl_req;
    logic              cl_we;
    logic [ADDR_W-1:0] cl_addr;
    logic [DATA_W-1:0] cl_wdata;
    logic              cl_gnt;
    logic              cl_rvalid;
    logic [DATA_W-1:0] cl_rdata;
    logic              cl_err;

    modport master (
        output cl_req, cl_we, cl_addr, cl_wdata,
        input  cl_gnt, cl_rvalid, cl_rdata, cl_err
    );

    modport slave (
        input  cl_req, cl_we, cl_addr, cl_wdata,
        output cl_gnt, cl_rvalid, cl_rdata, cl_err
    );

endinterface

// File: rtl/fb_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_addr_gen
// Display-side frame-buffer address generator. Keeps the base address of the
// current image row and adds the downscaled column to it.
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_disp          this cycle is a display fetch slot
//   i_animate       end of the last visible line: rewind to image row 0
//   i_col           visible column (0..639 when i_disp)
//   i_y             raw line count
//   o_addr          combinational fetch address for this cycle
// -----------------------------------------------------------------------------
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int SHIFT  = 1,
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_disp,
    input  logic              i_animate,
    input  logic [9:0]        i_col,
    input  logic [9:0]        i_y,
    output logic [ADDR_W-1:0] o_addr
);

    // Each image row is shown on 2^SHIFT display lines; the row base moves on
    // only after the last of them.
    localparam logic [9:0] Y_MASK = 10'((1 << SHIFT) - 1);

    logic [ADDR_W-1:0] r_row_base;
    logic              w_last_col;
    logic              w_last_rep;

    assign w_last_col = (i_col == 10'(H_ACTIVE - 1));
    assign w_last_rep = ((i_y & Y_MASK) == Y_MASK);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_row_base <= '0;
        end else if (i_animate) begin
            r_row_base <= '0;
        end else if (i_disp && w_last_col && w_last_rep) begin
            r_row_base <= r_row_base + ADDR_W'(IMG_W);
        end
    end

    assign o_addr = r_row_base + ADDR_W'(i_col >> SHIFT);

endmodule

// File: rtl/fb_display_arbiter.sv
// -----------------------------------------------------------------------------
// fb_display_arbiter
// Shares one single-port frame-buffer BRAM between the VGA display fetch and
// an image-filter client. Display strobes always own their cycle; the client
// gets cycles without a pixel strobe. The stored IMG_W x IMG_H image is
// upscaled by 2^SHIFT through address generation.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_pix_stb, i_active     timing-generator pixel strobe / visible flag
//   i_x, i_y                raw timing counters
//   i_animate, i_screenend  end-of-visible-area / end-of-screen pulses
//   cl                      client request port (slave modport)
//   o_pix_rgb               display pixel, 3 clk after its strobe
//   o_vblank                frame is in vertical blanking
//   o_mem_*                 registered BRAM command
//   i_mem_rdata             BRAM read data, 1 clk after o_mem_en
//
// state        | meaning
// -------------+----------------------------------------------------------
// ACTIVE_FRAME | visible lines being scanned; client writes held off
//              | when VBLANK_WR_ONLY is set
// VBLANK       | between animate and screenend; client writes allowed
//
// Slot tags travel with each access (tag1 at T+1, tag2 at T+2) so the
// returning read data is routed to the display or the client at T+3.
// -----------------------------------------------------------------------------
module fb_display_arbiter
    import fb_pkg::*;
#(
    parameter int IMG_W          = 320,
    parameter int IMG_H          = 240,
    parameter int SHIFT          = 1,
    parameter int ADDR_W         = 17,
    parameter int DATA_W         = 12,
    parameter int VBLANK_WR_ONLY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pix_stb,
    input  logic                 i_active,
    input  logic [9:0]           i_x,
    input  logic [9:0]           i_y,
    input  logic                 i_animate,
    input  logic                 i_screenend,
    fb_display_arbiter_if.slave  cl,
    output logic [DATA_W-1:0]    o_pix_rgb,
    output logic                 o_vblank,
    output logic                 o_mem_en,
    output logic                 o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [DATA_W-1:0]    o_mem_wdata,
    input  logic [DATA_W-1:0]    i_mem_rdata
);

    localparam logic [ADDR_W:0] IMG_SIZE = (ADDR_W + 1)'(IMG_W * IMG_H);

    state_e            r_state;
    slot_e             r_tag1;
    slot_e             r_tag2;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cl_err;
    logic              r_cl_rvalid;
    logic [DATA_W-1:0] r_cl_rdata;
    logic [DATA_W-1:0] r_pix_rgb;

    logic [9:0]        w_col;
    logic              w_disp_win;
    logic              w_allowed;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_disp_addr;
    slot_e             w_slot;

    assign w_col      = col_of(i_x);
    assign w_disp_win = i_active && (w_col < 10'(H_ACTIVE));

    // A write is only safe while blanking continues into the next cycle, so
    // the screenend cycle (where blanking ends) is excluded.
    assign w_allowed  = !cl.cl_we
                      || (VBLANK_WR_ONLY == 0)
                      || ((r_state == VBLANK) && !i_screenend);

    assign w_in_range = ({1'b0, cl.cl_addr} < IMG_SIZE);

    always_comb begin
        w_slot = NONE;
        if (i_pix_stb) begin
            w_slot = w_disp_win ? DISP : BLANK;
        end else if (cl.cl_req && w_allowed) begin
            w_slot = CLIENT;
        end
    end

    fb_addr_gen #(
        .IMG_W  (IMG_W),
        .SHIFT  (SHIFT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_disp    (w_slot == DISP),
        .i_animate (i_animate),
        .i_col     (w_col),
        .i_y       (i_y),
        .o_addr    (w_disp_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ACTIVE_FRAME;
            r_tag1      <= NONE;
            r_tag2      <= NONE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cl_err    <= 1'b0;
            r_cl_rvalid <= 1'b0;
            r_cl_rdata  <= '0;
            r_pix_rgb   <= '0;
        end else begin
            if (i_screenend) begin
                r_state <= ACTIVE_FRAME;
            end else if (i_animate) begin
                r_state <= VBLANK;
            end

            // Stage 1: issue the access chosen for this cycle.
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cl_err    <= 1'b0;
            r_tag1      <= NONE;
            case (w_slot)
                DISP: begin
                    r_mem_en   <= 1'b1;
                    r_mem_addr <= w_disp_addr;
                    r_tag1     <= DISP;
                end
                BLANK: begin
                    r_tag1 <= BLANK;
                end
                CLIENT: begin
                    if (w_in_range) begin
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= cl.cl_we;
                        r_mem_addr <= cl.cl_addr;
                        if (cl.cl_we) begin
                            r_mem_wdata <= cl.cl_wdata;
                        end else begin
                            r_tag1 <= CLIENT;
                        end
                    end else begin
                        r_cl_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Stage 2: BRAM is reading; carry the tag alongside.
            r_tag2 <= r_tag1;

            // Stage 3: route returning data to its owner.
            r_cl_rvalid <= 1'b0;
            case (r_tag2)
                DISP: begin
                    r_pix_rgb <= i_mem_rdata;
                end
                BLANK: begin
                    r_pix_rgb <= '0;
                end
                CLIENT: begin
                    r_cl_rdata  <= i_mem_rdata;
                    r_cl_rvalid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cl.cl_gnt    = (w_slot == CLIENT) && !i_reset;
    assign cl.cl_rvalid = r_cl_rvalid;
    assign cl.cl_rdata  = r_cl_rdata;
    assign cl.cl_err    = r_cl_err;

    assign o_pix_rgb    = r_pix_rgb;
    assign o_vblank     = (r_state == VBLANK);
    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_fb_display_arbiter.sv
module tb_fb_display_arbiter;

    localparam int AW   = 17;
    localparam int DW   = 12;
    localparam int NPIX = 320 * 240;
    localparam int MSZ  = 1 << AW;

    logic          clk;
    logic          reset;
    logic          pix_stb, active, animate, screenend;
    logic [9:0]    x, y;
    logic [DW-1:0] pix_rgb;
    logic          vblank;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    fb_display_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cl_if ();

    fb_display_arbiter #(
        .IMG_W(320), .IMG_H(240), .SHIFT(1),
        .ADDR_W(AW), .DATA_W(DW), .VBLANK_WR_ONLY(1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_pix_stb   (pix_stb),
        .i_active    (active),
        .i_x         (x),
        .i_y         (y),
        .i_animate   (animate),
        .i_screenend (screenend),
        .cl          (cl_if.slave),
        .o_pix_rgb   (pix_rgb),
        .o_vblank    (vblank),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default frame-buffer contents before any write.
    function automatic logic [11:0] pat(input int a);
        return 12'((a * 37 + 11) ^ (a >> 5));
    endfunction

    // BRAM model driven by the DUT command bus.
    logic [11:0] bram    [MSZ];
    bit          bram_wr [MSZ];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                bram[mem_addr]    <= mem_wdata;
                bram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= bram_wr[mem_addr] ? bram[mem_addr] : pat(int'(mem_addr));
            end
        end
    end

    // Reference model state: image contents as the client sees them,
    // frame phase, count of completed image rows since animate, and the
    // expected T+3 events of the last three cycles.
    logic [11:0] ref_mem [MSZ];
    bit          ref_wr  [MSZ];
    bit          m_vb;
    int          m_row;
    logic [11:0] exp_pix;
    logic [11:0] exp_rdata;
    typedef struct { int kind; logic [11:0] data; } exp3_t; // 0 none, 1 pixel, 2 black, 3 client read
    exp3_t pq [3];

    function automatic logic [11:0] ref_rd(input int a);
        return ref_wr[a] ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input bit p, input bit a, input int xx, input int yy, input bit an, input bit se);
        pix_stb = p; active = a; x = 10'(xx); y = 10'(yy); animate = an; screenend = se;
    endtask

    task automatic creq(input bit r, input bit w, input int ad, input int wd);
        cl_if.cl_req = r; cl_if.cl_we = w; cl_if.cl_addr = AW'(ad); cl_if.cl_wdata = DW'(wd);
    endtask

    // One clock cycle: predict from the current inputs, clock, then compare.
    task automatic tick(output bit mg, output logic dg);
        int col;
        bit disp, blank, cli, e_en, e_we, e_err, rst_now;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd;
        exp3_t n;
        n.kind = 0; n.data = '0;
        e_en = 0; e_we = 0; e_err = 0; e_a = '0; e_wd = '0; mg = 0;
        #1;
        dg = cl_if.cl_gnt;
        rst_now = reset;
        if (rst_now) begin
            chk("gnt_in_reset", dg, 0);
        end else begin
            col   = (int'(x) - 160) & 1023;
            disp  = pix_stb && active && (col < 640);
            blank = pix_stb && !disp;
            cli   = !pix_stb && cl_if.cl_req && (!cl_if.cl_we || (m_vb && !screenend));
            mg    = cli;
            chk("cl_gnt", dg, cli);
            if (disp) begin
                e_en = 1;
                e_a  = AW'((m_row * 320 + col / 2) % MSZ);
                n.kind = 1; n.data = ref_rd(int'(e_a));
            end else if (blank) begin
                n.kind = 2;
            end else if (cli) begin
                if (int'(cl_if.cl_addr) < NPIX) begin
                    e_en = 1; e_we = cl_if.cl_we; e_a = cl_if.cl_addr;
                    if (cl_if.cl_we) begin
                        e_wd = cl_if.cl_wdata;
                        ref_mem[cl_if.cl_addr] = cl_if.cl_wdata;
                        ref_wr[cl_if.cl_addr]  = 1'b1;
                    end else begin
                        n.kind = 3; n.data = ref_rd(int'(cl_if.cl_addr));
                    end
                end else begin
                    e_err = 1;
                end
            end
            if (disp && col == 639 && y[0]) m_row++;
            if (animate) m_row = 0;
            if (screenend) m_vb = 0;
            else if (animate) m_vb = 1;
        end
        @(posedge clk);
        #1;
        if (rst_now) begin
            m_vb = 0; m_row = 0; exp_pix = '0; exp_rdata = '0;
            for (int i = 0; i < 3; i++) begin pq[i].kind = 0; pq[i].data = '0; end
        end
        chk("mem_en", mem_en, e_en);
        chk("cl_err", cl_if.cl_err, e_err);
        if (e_en) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_a);
            if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        end
        chk("vblank", vblank, m_vb);
        pq[2] = pq[1]; pq[1] = pq[0]; pq[0] = n;
        if (pq[2].kind == 1) exp_pix = pq[2].data;
        if (pq[2].kind == 2) exp_pix = '0;
        if (pq[2].kind == 3) exp_rdata = pq[2].data;
        chk("pix_rgb", pix_rgb, exp_pix);
        chk("cl_rvalid", cl_if.cl_rvalid, pq[2].kind == 3);
        chk("cl_rdata", cl_if.cl_rdata, exp_rdata);
    endtask

    typedef struct { bit p; bit a; int xx; int yy; bit e_en; int e_addr; } vec_t;
    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   mg;
        logic dg;
        int   r, ad;

        tbl[0] = '{1, 1, 160, 0, 1, 0};
        tbl[1] = '{1, 1, 161, 0, 1, 0};
        tbl[2] = '{1, 1, 162, 0, 1, 1};
        tbl[3] = '{1, 1, 799, 0, 1, 319};
        tbl[4] = '{1, 1, 160, 1, 1, 0};
        tbl[5] = '{1, 1, 799, 1, 1, 319};
        tbl[6] = '{1, 1, 160, 2, 1, 320};
        tbl[7] = '{1, 1, 800, 2, 0, 0};
        tbl[8] = '{1, 0, 100, 2, 0, 0};

        m_vb = 0; m_row = 0; exp_pix = '0; exp_rdata = '0;
        for (int i = 0; i < 3; i++) begin pq[i].kind = 0; pq[i].data = '0; end

        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        creq(0, 0, 0, 0);
        repeat (2) tick(mg, dg);
        reset = 1'b0;
        chk("rst_pix", pix_rgb, 0);
        chk("rst_vblank", vblank, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid", cl_if.cl_rvalid, 0);
        chk("rst_rdata", cl_if.cl_rdata, 0);
        chk("rst_err", cl_if.cl_err, 0);

        // Address mapping and blank tokens.
        for (int i = 0; i < 9; i++) begin
            drv(tbl[i].p, tbl[i].a, tbl[i].xx, tbl[i].yy, 0, 0);
            tick(mg, dg);
            chk("tbl_en", mem_en, tbl[i].e_en);
            if (tbl[i].e_en) chk("tbl_addr", mem_addr, tbl[i].e_addr);
        end
        drv(0, 0, 0, 2, 0, 0);
        repeat (3) tick(mg, dg);
        chk("blank_pix_zero", pix_rgb, 0);

        for (int yy = 2; yy < 480; yy++) begin
            drv(1, 1, 799, yy, 0, 0);
            tick(mg, dg);
            if (yy == 479) chk("addr_last", mem_addr, 76799);
        end
        drv(0, 0, 0, 479, 0, 0);
        repeat (2) tick(mg, dg);
        chk("pix_last", pix_rgb, pat(76799));

        drv(0, 0, 0, 480, 1, 0);
        tick(mg, dg);
        chk("vb_enter", vblank, 1);
        drv(1, 1, 160, 0, 0, 0);
        tick(mg, dg);
        chk("addr_cleared", mem_addr, 0);
        drv(0, 0, 0, 0, 0, 1);
        tick(mg, dg);
        chk("vb_leave", vblank, 0);

        // Arbitration: read held across a display strobe.
        creq(1, 0, 5, 0);
        for (int k = 0; k < 6; k++) begin
            drv((k % 4) == 0, 1, 200, 10, 0, 0);
            tick(mg, dg);
            if (k == 0) chk("arb_pix_nogrant", dg, 0);
            if (k == 1) chk("arb_grant", dg, 1);
            if (mg) creq(0, 0, 0, 0);
            if (k == 3) begin
                chk("arb_rvalid", cl_if.cl_rvalid, 1);
                chk("arb_rdata", cl_if.cl_rdata, pat(5));
            end
        end

        // Tear-free write.
        creq(1, 1, 1234, 'hABC);
        for (int k = 0; k < 12; k++) begin
            drv((k % 4) == 0, 1, 300, 100, 0, 0);
            tick(mg, dg);
            chk("tf_withheld", dg, 0);
        end
        drv(0, 0, 0, 479, 1, 0);
        tick(mg, dg);
        chk("tf_anim_cycle", dg, 0);
        drv(0, 0, 0, 480, 0, 0);
        tick(mg, dg);
        chk("tf_grant", dg, 1);
        chk("tf_we", mem_we, 1);
        chk("tf_addr", mem_addr, 1234);
        chk("tf_wdata", mem_wdata, 'hABC);
        creq(0, 0, 0, 0);
        tick(mg, dg);
        creq(1, 1, 77, 'h123);
        drv(0, 0, 0, 520, 0, 1);
        tick(mg, dg);
        chk("tf_se_nogrant", dg, 0);
        drv(0, 0, 0, 0, 0, 0);
        tick(mg, dg);
        chk("tf_after_se", dg, 0);
        creq(1, 0, 1234, 0);
        tick(mg, dg);
        chk("rb_grant", dg, 1);
        creq(0, 0, 0, 0);
        repeat (2) tick(mg, dg);
        chk("rb_rvalid", cl_if.cl_rvalid, 1);
        chk("rb_rdata", cl_if.cl_rdata, 'hABC);

        // Out-of-range write.
        drv(0, 0, 0, 479, 1, 0);
        tick(mg, dg);
        drv(0, 0, 0, 480, 0, 0);
        creq(1, 1, 76800, 'h5A5);
        tick(mg, dg);
        chk("err_grant", dg, 1);
        chk("err_en", mem_en, 0);
        chk("err_pulse", cl_if.cl_err, 1);
        creq(0, 0, 0, 0);
        tick(mg, dg);
        chk("err_clear", cl_if.cl_err, 0);

        // Reset one cycle after a read grant.
        creq(1, 0, 9, 0);
        tick(mg, dg);
        chk("rst_rd_grant", dg, 1);
        creq(0, 0, 0, 0);
        reset = 1'b1;
        tick(mg, dg);
        reset = 1'b0;
        chk("mid_rst_pix", pix_rgb, 0);
        chk("mid_rst_vblank", vblank, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_rvalid", cl_if.cl_rvalid, 0);
        chk("mid_rst_err", cl_if.cl_err, 0);
        repeat (2) begin
            tick(mg, dg);
            chk("rst_no_rvalid", cl_if.cl_rvalid, 0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            int xx;
            bit aa;
            reset = ($urandom % 600) == 0;
            xx = (($urandom % 8) == 0) ? 799 : int'($urandom_range(0, 800));
            aa = (($urandom % 8) != 0) ? (xx >= 160 && xx < 800) : bit'($urandom % 2);
            drv(($urandom % 4) == 0, aa, xx, int'($urandom % 480),
                ($urandom % 150) == 0, ($urandom % 150) == 0);
            if (!cl_if.cl_req && ($urandom % 3) == 0) begin
                r = int'($urandom % 8);
                if (r == 0)      ad = int'($urandom_range(NPIX, MSZ - 1));
                else if (r < 5)  ad = int'($urandom % 16);
                else             ad = int'($urandom % NPIX);
                creq(1, bit'($urandom % 2), ad, int'($urandom % 4096));
            end
            tick(mg, dg);
            if (mg) creq(0, 0, 0, 0);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
